// File: rtl/color_class_overlay.sv
// Class-coloured overlay renderer with per-frame class pixel counters; 2-cycle fixed latency.
// Optional ALPHA_BLEND_EN: blend palette into source pixel instead of hard replacement.
module color_class_overlay #(
    parameter int CNT_W       = 20,
    parameter int ALPHA_SHIFT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_de,
    input  logic             i_hs,
    input  logic             i_vs,
    input  logic [7:0]       i_r,
    input  logic [7:0]       i_g,
    input  logic [7:0]       i_b,
    input  logic [1:0]       i_class,
    output logic             o_de,
    output logic             o_hs,
    output logic             o_vs,
    output logic [7:0]       o_r,
    output logic [7:0]       o_g,
    output logic [7:0]       o_b,
    output logic [CNT_W-1:0] o_cnt_red,
    output logic [CNT_W-1:0] o_cnt_blue,
    output logic [CNT_W-1:0] o_cnt_yel,
    output logic             o_cnt_valid
);

    logic        r_s1_de, r_s1_hs, r_s1_vs, r_s1_ovl;
    logic [23:0] r_s1_px, r_s1_pal;
    logic        r_en_lat;
    logic [23:0] w_pal, w_ovl;
    logic        w_vs_rise;

    logic [CNT_W-1:0] r_run [1:3];
    logic [CNT_W-1:0] r_cnt [1:3];

    // Stage-1 vs register doubles as the edge-detect delay.
    assign w_vs_rise = i_vs & ~r_s1_vs;

    always_comb begin
        w_pal = 24'h000000;
        case (i_class)
            2'b11:   w_pal = 24'hFF0000;
            2'b01:   w_pal = 24'h0000FF;
            2'b10:   w_pal = 24'hFFFF00;
            default: w_pal = 24'h000000;
        endcase
    end

`ifdef ALPHA_BLEND_EN
    for (genvar c = 0; c < 3; c++) begin : g_blend
        logic signed [9:0] w_diff, w_sum;
        assign w_diff = $signed({2'b00, r_s1_pal[c*8+:8]}) - $signed({2'b00, r_s1_px[c*8+:8]});
        assign w_sum  = $signed({2'b00, r_s1_px[c*8+:8]}) + (w_diff >>> ALPHA_SHIFT);
        assign w_ovl[c*8+:8] = w_sum[7:0];
    end
`else
    assign w_ovl = r_s1_pal;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_de  <= 1'b0;
            r_s1_hs  <= 1'b0;
            r_s1_vs  <= 1'b0;
            r_s1_ovl <= 1'b0;
            r_s1_px  <= 24'h0;
            r_s1_pal <= 24'h0;
            r_en_lat <= 1'b0;
            o_de     <= 1'b0;
            o_hs     <= 1'b0;
            o_vs     <= 1'b0;
            {o_r, o_g, o_b} <= 24'h0;
        end else begin
            r_s1_de  <= i_de;
            r_s1_hs  <= i_hs;
            r_s1_vs  <= i_vs;
            r_s1_ovl <= (i_class != 2'b00);
            r_s1_px  <= {i_r, i_g, i_b};
            r_s1_pal <= w_pal;
            if (w_vs_rise)
                r_en_lat <= i_en;
            o_de <= r_s1_de;
            o_hs <= r_s1_hs;
            o_vs <= r_s1_vs;
            // r_en_lat is already updated when the vs-rise pixel reaches this stage.
            if (!r_s1_de)
                {o_r, o_g, o_b} <= 24'h0;
            else if (!r_en_lat || !r_s1_ovl)
                {o_r, o_g, o_b} <= r_s1_px;
            else
                {o_r, o_g, o_b} <= w_ovl;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 1; k <= 3; k++) begin
                r_run[k] <= '0;
                r_cnt[k] <= '0;
            end
            o_cnt_valid <= 1'b0;
        end else begin
            o_cnt_valid <= w_vs_rise;
            for (int k = 1; k <= 3; k++) begin
                if (w_vs_rise) begin
                    r_cnt[k] <= r_run[k];
                    r_run[k] <= (i_de && i_class == 2'(k)) ? CNT_W'(1) : '0;
                end else if (i_de && i_class == 2'(k) && r_run[k] != '1) begin
                    r_run[k] <= r_run[k] + CNT_W'(1);
                end
            end
        end
    end

    assign o_cnt_red  = r_cnt[3];
    assign o_cnt_blue = r_cnt[1];
    assign o_cnt_yel  = r_cnt[2];

endmodule

// File: tb/tb_color_class_overlay.sv
// Bench for color_class_overlay: pixel scoreboard plus inline counter checks (CNT_W=20 and CNT_W=4).
module tb_color_class_overlay;

    localparam int ASH = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, de = 1'b0, hs = 1'b0, vs = 1'b0;
    logic [7:0] r = 8'h0, g = 8'h0, b = 8'h0;
    logic [1:0] cls = 2'b00;

    logic        o_de, o_hs, o_vs, o_cv;
    logic [7:0]  o_r, o_g, o_b;
    logic [19:0] o_cr, o_cb, o_cy;
    logic        p_de, p_hs, p_vs, p_cv;
    logic [7:0]  p_r, p_g, p_b;
    logic [3:0]  p_cr, p_cb, p_cy;

    color_class_overlay #(.CNT_W(20), .ALPHA_SHIFT(ASH)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_de(de), .i_hs(hs), .i_vs(vs),
        .i_r(r), .i_g(g), .i_b(b), .i_class(cls),
        .o_de(o_de), .o_hs(o_hs), .o_vs(o_vs), .o_r(o_r), .o_g(o_g), .o_b(o_b),
        .o_cnt_red(o_cr), .o_cnt_blue(o_cb), .o_cnt_yel(o_cy), .o_cnt_valid(o_cv));

    color_class_overlay #(.CNT_W(4), .ALPHA_SHIFT(ASH)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_de(de), .i_hs(hs), .i_vs(vs),
        .i_r(r), .i_g(g), .i_b(b), .i_class(cls),
        .o_de(p_de), .o_hs(p_hs), .o_vs(p_vs), .o_r(p_r), .o_g(p_g), .o_b(p_b),
        .o_cnt_red(p_cr), .o_cnt_blue(p_cb), .o_cnt_yel(p_cy), .o_cnt_valid(p_cv));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       de, hs, vs;
        logic [7:0] r, g, b;
    } pix_t;

    pix_t sb[$];
    int   n_vec = 0, n_err = 0;
    logic m_en = 1'b0, m_vs_d = 1'b0;
    pix_t mon_exp, mon_act, mon_act4;

    // Output for inputs driven at posedge+1 is visible at the negedge two edges later.
    always @(negedge clk) begin
        if (!rst && sb.size() == 3) begin
            mon_exp  = sb.pop_front();
            mon_act  = {o_de, o_hs, o_vs, o_r, o_g, o_b};
            mon_act4 = {p_de, p_hs, p_vs, p_r, p_g, p_b};
            n_vec++;
            if (mon_act !== mon_exp || mon_act4 !== mon_exp) begin
                n_err++;
                $display("FAIL pixel @%0t: got %h / %h, expected %h", $time, mon_act, mon_act4, mon_exp);
            end
        end
    end

    function automatic logic [7:0] ovl_ch(input logic [7:0] px, input logic [7:0] pal);
`ifdef ALPHA_BLEND_EN
        int d;
        d = int'(pal) - int'(px);
        return 8'(int'(px) + (d >>> ASH));
`else
        return pal;
`endif
    endfunction

    task automatic step(input logic s_de, input logic s_vs, input logic s_en,
                        input logic [7:0] s_r, input logic [7:0] s_g, input logic [7:0] s_b,
                        input logic [1:0] s_cls, input logic s_hs = 1'b0);
        pix_t e;
        logic [23:0] pal;
        @(posedge clk); #1;
        de = s_de; vs = s_vs; en = s_en; hs = s_hs;
        r = s_r; g = s_g; b = s_b; cls = s_cls;
        if (s_vs && !m_vs_d) m_en = s_en;
        m_vs_d = s_vs;
        case (s_cls)
            2'b11:   pal = 24'hFF0000;
            2'b01:   pal = 24'h0000FF;
            2'b10:   pal = 24'hFFFF00;
            default: pal = 24'h000000;
        endcase
        e.de = s_de; e.hs = s_hs; e.vs = s_vs;
        if (!s_de)                       {e.r, e.g, e.b} = 24'h0;
        else if (!m_en || s_cls == 2'b00) {e.r, e.g, e.b} = {s_r, s_g, s_b};
        else {e.r, e.g, e.b} = {ovl_ch(s_r, pal[23:16]), ovl_ch(s_g, pal[15:8]), ovl_ch(s_b, pal[7:0])};
        sb.push_back(e);
    endtask

    task automatic frame_start(input logic f_en);
        step(1'b0, 1'b1, f_en, 8'h0, 8'h0, 8'h0, 2'b00);
        step(1'b0, 1'b1, f_en, 8'h0, 8'h0, 8'h0, 2'b00);
        step(1'b0, 1'b0, f_en, 8'h0, 8'h0, 8'h0, 2'b00);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        m_en = 1'b0; m_vs_d = 1'b0;
        @(posedge clk); #1;
        {de, vs, en, hs, r, g, b, cls} = '0;
        rst = 1'b0;
        sb.push_back('0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            {de, vs, en, hs} = 4'($urandom);
            {r, g, b} = 24'($urandom);
            cls = 2'($urandom);
        end
        n_vec++;
        if ({o_de, o_hs, o_vs, o_r, o_g, o_b, o_cr, o_cb, o_cy, o_cv} !== '0 ||
            {p_de, p_hs, p_vs, p_r, p_g, p_b, p_cr, p_cb, p_cy, p_cv} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got de=%b rgb=%h cnt=%h/%h/%h v=%b, expected all 0",
                     o_de, {o_r, o_g, o_b}, o_cr, o_cb, o_cy, o_cv);
        end
        @(posedge clk); #1;
        {de, vs, en, hs, r, g, b, cls} = '0;
        rst = 1'b0;
        sb.delete();
        m_en = 1'b0; m_vs_d = 1'b0;
        sb.push_back('0);
        step(1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56, 2'b00);
        step(1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 2'b00);
    endtask

    task automatic test_replace();
        frame_start(1'b1);
        step(1'b1, 1'b0, 1'b1, 8'h40, 8'h50, 8'h60, 2'b11);
        step(1'b1, 1'b0, 1'b1, 8'h40, 8'h50, 8'h60, 2'b00);
        step(1'b0, 1'b0, 1'b1, 8'h40, 8'h50, 8'h60, 2'b11);
        step(1'b1, 1'b0, 1'b1, 8'h40, 8'h50, 8'h60, 2'b01);
        step(1'b1, 1'b0, 1'b1, 8'h40, 8'h50, 8'h60, 2'b10, 1'b1);
    endtask

    task automatic test_blend();
        frame_start(1'b1);
        step(1'b1, 1'b0, 1'b1, 8'd80, 8'd80, 8'd80, 2'b01);
        step(1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 2'b10);
        step(1'b1, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h01, 2'b11);
    endtask

    task automatic test_enable_timing();
        frame_start(1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 2'b11);
        step(1'b1, 1'b0, 1'b1, 8'h11, 8'h22, 8'h33, 2'b11);
        step(1'b1, 1'b0, 1'b1, 8'h11, 8'h22, 8'h33, 2'b01);
        step(1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33, 2'b11);
        step(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 2'b00);
        step(1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 2'b11);
        step(1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33, 2'b10);
    endtask

    task automatic test_counters();
        logic [1:0] c;
        frame_start(1'b1);
        for (int i = 0; i < 100; i++) begin
            c = (i < 30) ? 2'b11 : (i < 50) ? 2'b01 : (i < 60) ? 2'b10 : 2'b00;
            step(1'b1, 1'b0, 1'b1, 8'(i), 8'(i * 3), 8'(i * 7), c);
            if (i % 10 == 0) step(1'b0, 1'b0, 1'b1, 8'h0, 8'h0, 8'h0, 2'b11);
        end
        // Red pixel on the vs-rise cycle belongs to the new frame.
        step(1'b1, 1'b1, 1'b1, 8'h01, 8'h02, 8'h03, 2'b11);
        step(1'b0, 1'b1, 1'b1, 8'h0, 8'h0, 8'h0, 2'b00);
        n_vec++;
        if ({o_cv, o_cr, o_cb, o_cy} !== {1'b1, 20'd30, 20'd20, 20'd10}) begin
            n_err++;
            $display("FAIL frame_counts: got v=%b %0d/%0d/%0d, expected v=1 30/20/10", o_cv, o_cr, o_cb, o_cy);
        end
        n_vec++;
        if ({p_cv, p_cr, p_cb, p_cy} !== {1'b1, 4'd15, 4'd15, 4'd10}) begin
            n_err++;
            $display("FAIL saturation: got v=%b %0d/%0d/%0d, expected v=1 15/15/10", p_cv, p_cr, p_cb, p_cy);
        end
        step(1'b0, 1'b0, 1'b1, 8'h0, 8'h0, 8'h0, 2'b00);
        n_vec++;
        if (o_cv !== 1'b0 || p_cv !== 1'b0) begin
            n_err++;
            $display("FAIL valid_pulse_width: got %b/%b, expected 0", o_cv, p_cv);
        end
        step(1'b1, 1'b0, 1'b1, 8'h0, 8'h0, 8'h0, 2'b01);
        step(1'b1, 1'b0, 1'b1, 8'h0, 8'h0, 8'h0, 2'b01);
        frame_start(1'b1);
        n_vec++;
        if ({o_cr, o_cb, o_cy} !== {20'd1, 20'd2, 20'd0}) begin
            n_err++;
            $display("FAIL boundary_clear: got %0d/%0d/%0d, expected 1/2/0", o_cr, o_cb, o_cy);
        end
    endtask

    task automatic test_reset_midframe();
        frame_start(1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'h0, 8'h0, 8'h0, 2'b11);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h0, 8'h0, 8'h0, 2'b00);
            n_vec++;
            if (o_cv !== 1'b0 || o_cr !== 20'd0) begin
                n_err++;
                $display("FAIL reset_midframe_quiet: got v=%b red=%0d, expected v=0 red=0", o_cv, o_cr);
            end
        end
        step(1'b0, 1'b1, 1'b1, 8'h0, 8'h0, 8'h0, 2'b00);
        step(1'b0, 1'b1, 1'b1, 8'h0, 8'h0, 8'h0, 2'b00);
        n_vec++;
        if ({o_cv, o_cr} !== {1'b1, 20'd0}) begin
            n_err++;
            $display("FAIL reset_midframe_discard: got v=%b red=%0d, expected v=1 red=0", o_cv, o_cr);
        end
        step(1'b1, 1'b0, 1'b1, 8'h77, 8'h88, 8'h99, 2'b11);
    endtask

    task automatic test_back_to_back();
        logic f_en;
        f_en = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i % 40 == 0) f_en = 1'($urandom);
            step((i % 40 >= 2) && ($urandom_range(0, 3) != 0), (i % 40 < 2),
                 (i % 40 < 2) ? f_en : 1'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_replace();
`ifdef ALPHA_BLEND_EN
        test_blend();
`endif
        test_enable_timing();
        test_counters();
        test_reset_midframe();
        test_back_to_back();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 2'b00);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
